// File: rtl/seven_seg_decoder.sv
// Recovers hex digits from a multiplexed 7-segment scan bus (active-low anodes/segments)
// and publishes one complete frame of nibbles and valid/bad flags each time the scan wraps.
module seven_seg_decoder #(
    parameter int STABLE_SAMPLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [7:0]  anodes,
    input  logic [6:0]  segments,
    output logic [31:0] digits,
    output logic [7:0]  digits_valid,
    output logic [7:0]  bad_pattern,
    output logic        frame_done,
    output logic        multi_err
);

    typedef enum logic {
        EMPTY,
        COLLECT
    } frame_state_t;

    localparam logic [3:0] STABLE_N = STABLE_SAMPLES[3:0];

    // Returns {legal, nibble}; segments are bit6=g .. bit0=a, active low.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? 4'hF : c + 4'd1;
    endfunction

    frame_state_t state_p0;
    logic [3:0]   cnt_p0;
    logic [2:0]   prev_idx_p0;
    logic [6:0]   prev_seg_p0;
    logic [2:0]   last_idx_p0;
    logic [31:0]  work_dig_p0;
    logic [7:0]   work_vld_p0;
    logic [7:0]   work_bad_p0;

    logic [3:0]   n_low;
    logic [2:0]   idx;
    logic         is_single;
    logic         is_multi;
    logic         same_pat;
    logic [3:0]   cnt_nx;
    logic         commit;
    logic         boundary;
    logic         legal;
    logic [3:0]   nib;
    logic [31:0]  dig_nx;
    logic [7:0]   vld_nx;
    logic [7:0]   bad_nx;

    always_comb begin
        n_low = '0;
        idx   = '0;
        for (int i = 0; i < 8; i++) begin
            if (!anodes[i]) begin
                n_low = n_low + 4'd1;
                idx   = 3'(i);
            end
        end
    end

    assign is_single = (n_low == 4'd1);
    assign is_multi  = (n_low > 4'd1);

    // A nonzero count already implies the previous sample was a single.
    assign same_pat = is_single && (cnt_p0 != 4'd0) &&
                      (idx == prev_idx_p0) && (segments == prev_seg_p0);

    always_comb begin
        if (!is_single)
            cnt_nx = 4'd0;
        else if (same_pat)
            cnt_nx = sat_inc(cnt_p0);
        else
            cnt_nx = 4'd1;
    end

    // Commit only on the transition into STABLE_N, so a held or saturated pattern fires once.
    assign commit   = is_single && (cnt_nx == STABLE_N) && !(same_pat && (cnt_p0 >= STABLE_N));
    assign boundary = commit && (state_p0 == COLLECT) && (idx <= last_idx_p0);
    assign {legal, nib} = decode_seg(segments);

    always_comb begin
        dig_nx = work_dig_p0;
        vld_nx = boundary ? 8'h00 : work_vld_p0;
        bad_nx = boundary ? 8'h00 : work_bad_p0;
        for (int i = 0; i < 8; i++) begin
            if (idx == 3'(i)) begin
                vld_nx[i] = legal;
                bad_nx[i] = !legal;
                if (legal)
                    dig_nx[4*i +: 4] = nib;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce && is_single) begin
            prev_idx_p0 <= idx;
            prev_seg_p0 <= segments;
        end
    end

    // ---- sample stage: classify, stabilise, commit, publish ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0     <= EMPTY;
            cnt_p0       <= 4'd0;
            last_idx_p0  <= 3'd0;
            work_dig_p0  <= '0;
            work_vld_p0  <= '0;
            work_bad_p0  <= '0;
            digits       <= '0;
            digits_valid <= '0;
            bad_pattern  <= '0;
            frame_done   <= 1'b0;
            multi_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            multi_err  <= 1'b0;
            if (ce) begin
                multi_err <= is_multi;
                cnt_p0    <= cnt_nx;
                if (commit) begin
                    state_p0    <= COLLECT;
                    last_idx_p0 <= idx;
                    work_dig_p0 <= dig_nx;
                    work_vld_p0 <= vld_nx;
                    work_bad_p0 <= bad_nx;
                    if (boundary) begin
                        digits       <= work_dig_p0;
                        digits_valid <= work_vld_p0;
                        bad_pattern  <= work_bad_p0;
                        frame_done   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed bench for seven_seg_decoder: scan frames, masks, illegal/multi samples, resets, stability.
module tb_seven_seg_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, rst3, ce3;
    logic [7:0]  anodes, anodes3;
    logic [6:0]  segments, segments3;
    logic [31:0] digits, digits3;
    logic [7:0]  digits_valid, digits_valid3, bad_pattern, bad_pattern3;
    logic        frame_done, frame_done3, multi_err, multi_err3;

    seven_seg_decoder #(.STABLE_SAMPLES(1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .anodes(anodes), .segments(segments),
        .digits(digits), .digits_valid(digits_valid), .bad_pattern(bad_pattern),
        .frame_done(frame_done), .multi_err(multi_err)
    );

    seven_seg_decoder #(.STABLE_SAMPLES(3)) dut3 (
        .clk(clk), .rst(rst3), .ce(ce3), .anodes(anodes3), .segments(segments3),
        .digits(digits3), .digits_valid(digits_valid3), .bad_pattern(bad_pattern3),
        .frame_done(frame_done3), .multi_err(multi_err3)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  v;
        logic [7:0]  b;
    } frame_t;

    frame_t     sb1[$];
    frame_t     sb3[$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] seg_tab [16];
    frame_t     f_none;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step1(input logic r, input logic c, input logic [7:0] an, input logic [6:0] sg,
                         input bit bnd, input frame_t ef, input bit em);
        frame_t f;
        rst = r; ce = c; anodes = an; segments = sg;
        if (bnd) sb1.push_back(ef);
        @(posedge clk); #1;
        chk("frame_done", 32'(frame_done), 32'(bnd));
        chk("multi_err", 32'(multi_err), 32'(em));
        if (sb1.size() > 0) begin
            f = sb1.pop_front();
            if (frame_done) begin
                chk("digits", digits, f.d);
                chk("digits_valid", 32'(digits_valid), 32'(f.v));
                chk("bad_pattern", 32'(bad_pattern), 32'(f.b));
            end
        end
    endtask

    task automatic step3(input logic r, input logic [7:0] an, input logic [6:0] sg,
                         input bit bnd, input frame_t ef);
        frame_t f;
        rst3 = r; ce3 = 1'b1; anodes3 = an; segments3 = sg;
        if (bnd) sb3.push_back(ef);
        @(posedge clk); #1;
        chk("s3_frame_done", 32'(frame_done3), 32'(bnd));
        if (sb3.size() > 0) begin
            f = sb3.pop_front();
            if (frame_done3) begin
                chk("s3_digits", digits3, f.d);
                chk("s3_digits_valid", 32'(digits_valid3), 32'(f.v));
                chk("s3_bad_pattern", 32'(bad_pattern3), 32'(f.b));
            end
        end
    endtask

    // One scan pass over ndig digit positions; masked-off positions are blanked.
    task automatic scan_pass(input logic [31:0] dg, input logic [7:0] mask, input bit bnd,
                             input frame_t ef, input int ndig, input int bad_digit);
        bit first = 1'b1;
        logic [7:0] an;
        logic [6:0] sg;
        for (int i = 0; i < ndig; i++) begin
            if (mask[i]) begin
                an = ~(8'h01 << i);
                sg = (i == bad_digit) ? 7'h7F : seg_tab[dg[4*i +: 4]];
                step1(1'b0, 1'b1, an, sg, bnd && first, ef, 1'b0);
                first = 1'b0;
            end else begin
                step1(1'b0, 1'b1, 8'hFF, 7'h7F, 1'b0, ef, 1'b0);
            end
        end
    endtask

    task automatic check_cleared();
        chk("rst_digits", digits, 32'h0);
        chk("rst_digits_valid", 32'(digits_valid), 32'h0);
        chk("rst_bad_pattern", 32'(bad_pattern), 32'h0);
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
        seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110;
        seg_tab[15] = 7'b0001110;
        f_none = '0;
        rst3 = 1'b1; ce3 = 1'b0; anodes3 = 8'hFF; segments3 = 7'h7F;

        // Reset with ce=1 and a live sample: reset wins.
        step1(1'b1, 1'b1, 8'hFE, seg_tab[1], 1'b0, f_none, 1'b0);
        check_cleared();

        // Loopback: first pass fills, each later wrap publishes the full frame.
        scan_pass(32'h89ABCDEF, 8'hFF, 1'b0, f_none, 8, -1);
        scan_pass(32'h89ABCDEF, 8'hFF, 1'b1, '{32'h89ABCDEF, 8'hFF, 8'h00}, 8, -1);
        scan_pass(32'h89ABCDEF, 8'hFF, 1'b1, '{32'h89ABCDEF, 8'hFF, 8'h00}, 8, -1);

        // Reset after 4 digits of a new frame; the partial frame is discarded.
        scan_pass(32'h89ABCDEF, 8'hFF, 1'b1, '{32'h89ABCDEF, 8'hFF, 8'h00}, 4, -1);
        step1(1'b1, 1'b1, 8'hEF, seg_tab[12], 1'b0, f_none, 1'b0);
        check_cleared();

        // Partial mask after reset: nothing until a full frame plus a wrap.
        scan_pass(32'h00000321, 8'h05, 1'b0, f_none, 8, -1);
        scan_pass(32'h00000321, 8'h05, 1'b1, '{32'h00000301, 8'h05, 8'h00}, 8, -1);

        // Illegal pattern on digit 2: flagged bad, nibble kept.
        scan_pass(32'h00000321, 8'h05, 1'b1, '{32'h00000301, 8'h05, 8'h00}, 8, 2);
        scan_pass(32'h00000321, 8'h05, 1'b1, '{32'h00000301, 8'h01, 8'h04}, 8, -1);

        // Held pattern does not re-commit; ce=0 is ignored; multi clears the count.
        step1(1'b0, 1'b1, 8'hFE, seg_tab[1], 1'b1, '{32'h00000301, 8'h05, 8'h00}, 1'b0);
        step1(1'b0, 1'b1, 8'hFE, seg_tab[1], 1'b0, f_none, 1'b0);
        step1(1'b0, 1'b0, 8'hFC, seg_tab[1], 1'b0, f_none, 1'b0);
        step1(1'b0, 1'b1, 8'hFC, seg_tab[1], 1'b0, f_none, 1'b1);
        step1(1'b0, 1'b1, 8'hFE, seg_tab[1], 1'b1, '{32'h00000301, 8'h01, 8'h00}, 1'b0);
        ce = 1'b0; rst = 1'b0;

        // STABLE_SAMPLES=3: glitch ignored, held pattern commits exactly once.
        step3(1'b1, 8'hFF, 7'h7F, 1'b0, f_none);
        chk("s3_rst_digits", digits3, 32'h0);
        chk("s3_rst_multi_err", 32'(multi_err3), 32'h0);
        for (int k = 0; k < 3; k++) step3(1'b0, 8'hFE, seg_tab[1], 1'b0, f_none);
        step3(1'b0, 8'hEF, seg_tab[7], 1'b0, f_none);
        for (int k = 0; k < 5; k++) step3(1'b0, 8'hEF, seg_tab[5], 1'b0, f_none);
        step3(1'b0, 8'hFE, seg_tab[1], 1'b0, f_none);
        step3(1'b0, 8'hFE, seg_tab[1], 1'b0, f_none);
        step3(1'b0, 8'hFE, seg_tab[1], 1'b1, '{32'h00050001, 8'h11, 8'h00});

        chk("sb1_drained", 32'(sb1.size()), 32'h0);
        chk("sb3_drained", 32'(sb3.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_decoder.md
SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

Interface
REQ-001 SHALL have parameter STABLE_SAMPLES, default 1, meaning the number of consecutive identical ce samples needed before a digit is committed (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ce, input, 1, sample strobe; inputs are sampled only on clk edges with ce=1.
REQ-005 SHALL have port anodes, input, 8, active-low digit enables from the display scan bus.
REQ-006 SHALL have port segments, input, 7, active-low segments, bit0=a .. bit6=g (1 = segment off).
REQ-007 SHALL have port digits, output, 32, published nibbles, digit i at bits [4i+3:4i].
REQ-008 SHALL have port digits_valid, output, 8, published per-digit flags: a legal pattern was committed in the last completed frame.
REQ-009 SHALL have port bad_pattern, output, 8, published per-digit flags: an illegal pattern was committed in the last completed frame.
REQ-010 SHALL have port frame_done, output, 1, one-clk pulse when the published outputs update.
REQ-011 SHALL have port multi_err, output, 1, one-clk pulse when a sample has more than one anode low.

Function
REQ-012 SHALL classify each ce sample as: single (exactly one anodes bit 0, index = that bit), blank (all 1), or multi (two or more bits 0).
REQ-013 SHALL keep a 4-bit saturating stability count: on a single sample with the same index and segments as the previous single sample, count+1 (saturate at 15); on any other single sample, count=1; on blank or multi, count=0.
REQ-014 SHALL commit on the same edge where the count becomes exactly STABLE_SAMPLES; a held pattern SHALL NOT re-commit while the count stays at or above STABLE_SAMPLES.
REQ-015 SHALL decode on commit using the hex table 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bits g..a).
REQ-016 SHALL, on a legal commit, write the nibble into working digit[index], set working valid[index], and clear working bad[index].
REQ-017 SHALL, on an illegal commit, keep working digit[index], clear working valid[index], and set working bad[index].
REQ-018 SHALL use a two-state frame FSM: EMPTY (no commit since reset) and COLLECT; the first commit moves EMPTY->COLLECT without a frame boundary.
REQ-019 SHALL, in COLLECT, declare a frame boundary when a commit has index <= the last committed index (scan wrapped or repeated).
REQ-020 SHALL, at a boundary edge, copy working digits/valid/bad to the outputs, then clear working valid/bad and apply the triggering commit to the fresh working set.
REQ-021 SHALL drive frame_done high for exactly the one clk following the boundary edge, with the new outputs visible that same cycle.
REQ-022 SHALL drive multi_err high for the one clk following a multi sample; a multi sample SHALL neither commit nor cause a boundary.
REQ-023 SHALL treat blank samples as neutral: no commit, no boundary, last committed index retained.
REQ-024 SHALL ignore anodes/segments entirely on edges with ce=0; no state changes.

Reset
REQ-025 SHALL, with rst=1 at a clk edge, set digits=0, digits_valid=0, bad_pattern=0, frame_done=0, multi_err=0, clear working registers, count=0, FSM=EMPTY; rst SHALL take priority over ce.
REQ-026 SHALL, on reset mid-frame, discard the partial working frame; no frame_done is generated for it.

Verification
REQ-027 SHALL pass loopback: the 8-digit scan driver with ce=1 every clk, digits=0x89ABCDEF, mask=0xFF, STABLE_SAMPLES=1 -> after the second wrap, digits=0x89ABCDEF, digits_valid=0xFF, bad_pattern=0, frame_done once every 8 clks.
REQ-028 SHALL pass partial mask: mask=0x05, digits=0x00000321 -> digits_valid=0x05, digits[11:8]=3, digits[3:0]=1, frame_done every 8 clks.
REQ-029 SHALL pass illegal pattern: digit 2 driven with segments=1111111 -> bad_pattern[2]=1, digits_valid[2]=0, digit 2 nibble unchanged.
REQ-030 SHALL pass multi-anode: one sample with anodes=11111100 -> multi_err pulses one clk, no commit, count=0.
REQ-031 SHALL pass stability: STABLE_SAMPLES=3, one-sample glitch pattern on digit 4 -> not committed; a pattern held 5 samples -> committed once.
REQ-032 SHALL pass reset mid-frame: rst after 4 of 8 digits -> all outputs 0 next clk, first frame_done only after a full new frame plus a wrap.
